// File: rtl/sa_cache.sv
// sa_cache: two-way set-associative, write-back, write-allocate data cache with per-set LRU.
// Hit/miss statistics counters are built only when CACHE_STATS_EN is defined.
module sa_cache #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned SETS   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - IDX_W - 2;
    localparam int unsigned WORD_W = ADDR_W - 2;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        REFILL,
        RESPOND
    } state_t;

    state_t state_q, state_nxt;

    logic [TAG_W-1:0]  tag_mem  [2][SETS];
    logic [DATA_W-1:0] data_mem [2][SETS];
    logic [1:0]        valid_q  [SETS];
    logic [1:0]        dirty_q  [SETS];
    logic [SETS-1:0]   lru_q;

    // Accepted request, held so the access completes even if cpu_req drops
    logic [WORD_W-1:0] req_word_q;
    logic              req_we_q;
    logic [3:0]        req_be_q;
    logic [DATA_W-1:0] req_wdata_q;
    logic              way_q;

    logic [IDX_W-1:0]  look_idx;
    logic [TAG_W-1:0]  look_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit0, hit1, hit, victim, victim_dirty;
    logic [DATA_W-1:0] merged;

    logic              accept, hit_ev, miss_ev, wb_done, fill, commit;
    logic              cpu_ready_nxt, mem_req_nxt, mem_we_nxt;
    logic [DATA_W-1:0] cpu_rdata_nxt, mem_wdata_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;

    logic addr_lsb_unused;
    assign addr_lsb_unused = ^cpu_addr[1:0];

    assign look_idx = cpu_addr[IDX_W+1:2];
    assign look_tag = cpu_addr[ADDR_W-1:IDX_W+2];
    assign req_idx  = req_word_q[IDX_W-1:0];
    assign req_tag  = req_word_q[WORD_W-1:IDX_W];

    // Tag compare and victim choice: first invalid way (way0 first), else LRU way
    always_comb begin
        hit0 = valid_q[look_idx][0] && (tag_mem[0][look_idx] == look_tag);
        hit1 = valid_q[look_idx][1] && (tag_mem[1][look_idx] == look_tag);
        hit  = hit0 || hit1;
        if (!valid_q[look_idx][0]) begin
            victim = 1'b0;
        end else if (!valid_q[look_idx][1]) begin
            victim = 1'b1;
        end else begin
            victim = lru_q[look_idx];
        end
        victim_dirty = valid_q[look_idx][victim] && dirty_q[look_idx][victim];
    end

    always_comb begin
        merged = data_mem[way_q][req_idx];
        for (int i = 0; i < 4; i++) begin
            if (req_be_q[i]) begin
                merged[8*i +: 8] = req_wdata_q[8*i +: 8];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state_q;
        cpu_ready_nxt = 1'b0;
        cpu_rdata_nxt = cpu_rdata;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        accept        = 1'b0;
        hit_ev        = 1'b0;
        miss_ev       = 1'b0;
        wb_done       = 1'b0;
        fill          = 1'b0;
        commit        = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    accept = 1'b1;
                    if (hit) begin
                        hit_ev        = 1'b1;
                        state_nxt     = RESPOND;
                        cpu_ready_nxt = 1'b1;
                        cpu_rdata_nxt = data_mem[hit1][look_idx];
                    end else begin
                        miss_ev     = 1'b1;
                        mem_req_nxt = 1'b1;
                        if (victim_dirty) begin
                            state_nxt     = WRITEBACK;
                            mem_we_nxt    = 1'b1;
                            mem_addr_nxt  = {tag_mem[victim][look_idx], look_idx, 2'b00};
                            mem_wdata_nxt = data_mem[victim][look_idx];
                        end else begin
                            state_nxt    = REFILL;
                            mem_we_nxt   = 1'b0;
                            mem_addr_nxt = {cpu_addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack) begin
                    wb_done      = 1'b1;
                    state_nxt    = REFILL;
                    mem_we_nxt   = 1'b0;
                    mem_addr_nxt = {req_word_q, 2'b00};
                end
            end
            REFILL: begin
                if (mem_ack) begin
                    fill          = 1'b1;
                    state_nxt     = RESPOND;
                    mem_req_nxt   = 1'b0;
                    cpu_ready_nxt = 1'b1;
                    cpu_rdata_nxt = mem_rdata;
                end
            end
            default: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q   <= state_nxt;
            cpu_ready <= cpu_ready_nxt;
            cpu_rdata <= cpu_rdata_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_word_q  <= cpu_addr[ADDR_W-1:2];
            req_we_q    <= cpu_we;
            req_be_q    <= cpu_be;
            req_wdata_q <= cpu_wdata;
            way_q       <= hit ? hit1 : victim;
        end
    end

    // Line status and replacement state; cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
            lru_q <= '0;
        end else begin
            if (wb_done) begin
                dirty_q[req_idx][way_q] <= 1'b0;
            end
            if (fill) begin
                valid_q[req_idx][way_q] <= 1'b1;
                dirty_q[req_idx][way_q] <= 1'b0;
            end
            if (commit) begin
                lru_q[req_idx] <= ~way_q;
                if (req_we_q && (req_be_q != 4'b0000)) begin
                    dirty_q[req_idx][way_q] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[way_q][req_idx]  <= req_tag;
            data_mem[way_q][req_idx] <= mem_rdata;
        end else if (commit && req_we_q) begin
            data_mem[way_q][req_idx] <= merged;
        end
    end

`ifdef CACHE_STATS_EN
    // Saturating hit/miss counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_ev && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_ev && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`else
    logic stats_unused;
    assign stats_unused = hit_ev ^ miss_ev;
    assign hit_count    = '0;
    assign miss_count   = '0;
`endif

endmodule

// File: tb/tb_sa_cache.sv
// tb_sa_cache: random and directed accesses against a recency-list cache model and a word memory,
// with a scoreboard monitor checking every cpu_ready and the memory traffic behind it.
`timescale 1ns/1ps
module tb_sa_cache;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned SETS   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [3:0]  cpu_be = 4'b0;
    logic [31:0] cpu_addr = 32'b0;
    logic [31:0] cpu_wdata = 32'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    sa_cache #(.ADDR_W(ADDR_W), .SETS(SETS)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    typedef struct {
        bit        we;
        bit [31:0] rdata;
        bit        hit;
        bit        wb;
        bit [31:0] wb_addr;
        bit [31:0] wb_data;
        bit [31:0] rf_addr;
        int        issue;
    } exp_t;

    exp_t sb[$];

    // Reference: architectural memory plus recency-ordered list of resident words
    bit [31:0]   bmem    [int unsigned];
    bit [31:0]   arch    [int unsigned];
    bit          dirty_m [int unsigned];
    int unsigned res[$];
    int unsigned m_hits = 0;
    int unsigned m_misses = 0;

    function automatic bit [31:0] bmem_get(int unsigned w);
        if (bmem.exists(w)) return bmem[w];
        return (w * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic bit [31:0] arch_get(int unsigned w);
        if (arch.exists(w)) return arch[w];
        return bmem_get(w);
    endfunction

    function automatic void model_reset();
        res.delete();
        dirty_m.delete();
        arch.delete();
        m_hits   = 0;
        m_misses = 0;
    endfunction

    function automatic exp_t model_access(bit [31:0] addr, bit we, bit [3:0] be, bit [31:0] wd, int issue);
        exp_t        e;
        int unsigned w;
        int unsigned s;
        int          pos;
        int          cnt;
        int          last;
        int unsigned v;
        bit [31:0]   d;
        e = '{default: 0};
        e.we = we;
        e.issue = issue;
        w = addr >> 2;
        s = w % SETS;
        pos = -1;
        for (int i = 0; i < res.size(); i++) if (res[i] == w) pos = i;
        e.hit = (pos >= 0);
        if (e.hit) begin
            res.delete(pos);
            m_hits++;
        end else begin
            m_misses++;
            cnt = 0;
            last = -1;
            for (int i = 0; i < res.size(); i++) begin
                if (res[i] % SETS == s) begin
                    cnt++;
                    last = i;
                end
            end
            if (cnt == 2) begin
                v = res[last];
                res.delete(last);
                if (dirty_m.exists(v) && dirty_m[v]) begin
                    e.wb = 1'b1;
                    e.wb_addr = v << 2;
                    e.wb_data = arch_get(v);
                    dirty_m[v] = 1'b0;
                end
            end
            e.rf_addr = w << 2;
        end
        res.push_front(w);
        d = arch_get(w);
        if (we) begin
            for (int b = 0; b < 4; b++) if (be[b]) d[8*b +: 8] = wd[8*b +: 8];
            arch[w] = d;
            if (be != 4'b0000) dirty_m[w] = 1'b1;
        end else begin
            e.rdata = d;
        end
        return e;
    endfunction

    // Memory responder: records traffic seen between completions
    int        fixed_delay = -1;
    int        n_wb = 0;
    int        n_rf = 0;
    bit [31:0] wb_addr_seen, wb_data_seen, rf_addr_seen;

    initial begin : responder
        int d;
        bit abort;
        bit was_wb;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                abort = 1'b0;
                for (int k = 0; k < d; k++) begin
                    @(negedge clk);
                    if (rst || !mem_req) abort = 1'b1;
                end
                if (!abort && !rst && mem_req) begin
                    was_wb = mem_we;
                    if (mem_we) begin
                        n_wb++;
                        wb_addr_seen = mem_addr;
                        wb_data_seen = mem_wdata;
                        bmem[mem_addr >> 2] = mem_wdata;
                    end else begin
                        n_rf++;
                        rf_addr_seen = mem_addr;
                        mem_rdata = bmem_get(mem_addr >> 2);
                    end
                    mem_ack = 1'b1;
                    @(negedge clk);
                    mem_ack = 1'b0;
                    if (was_wb && !rst) check("wb_then_refill_req_we", {30'b0, mem_req, mem_we}, 32'd2);
                end
            end
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (cpu_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_ready", 32'(cpu_ready), 32'd0);
                end else begin
                    e = sb.pop_front();
                    if (!e.we) check("load_rdata", cpu_rdata, e.rdata);
                    if (e.hit) check("hit_latency", 32'(cyc - e.issue), 32'd1);
                    check("writeback_count", 32'(n_wb), 32'(e.wb));
                    if (e.wb && n_wb == 1) begin
                        check("writeback_addr", wb_addr_seen, e.wb_addr);
                        check("writeback_data", wb_data_seen, e.wb_data);
                    end
                    check("refill_count", 32'(n_rf), e.hit ? 32'd0 : 32'd1);
                    if (!e.hit && n_rf == 1) check("refill_addr", rf_addr_seen, e.rf_addr);
                end
                n_wb = 0;
                n_rf = 0;
            end
        end
    end

    task automatic do_access(bit [31:0] addr, bit we, bit [3:0] be, bit [31:0] wd);
        int t;
        @(negedge clk);
        sb.push_back(model_access(addr, we, be, wd, cyc));
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_be    = be;
        cpu_addr  = addr;
        cpu_wdata = wd;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cpu_ready && t < 200);
        if (!cpu_ready) begin
            check("ready_timeout", 32'(cpu_ready), 32'd1);
            sb.delete();
        end
        cpu_req = 1'b0;
    endtask

    task automatic check_stats(string tag);
`ifdef CACHE_STATS_EN
        check({tag, "_hit_count"}, hit_count, m_hits);
        check({tag, "_miss_count"}, miss_count, m_misses);
`else
        check({tag, "_hit_count"}, hit_count, 32'd0);
        check({tag, "_miss_count"}, miss_count, 32'd0);
`endif
    endtask

    initial begin : stim
        int t;
        bmem[32'h100 >> 2] = 32'hDEAD_BEEF;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
        rst = 1'b0;

        // Directed scenario: refill, hit, byte store, dirty eviction, LRU keep
        fixed_delay = 3;
        do_access(32'h100, 1'b0, 4'b0000, 32'h0);
        do_access(32'h100, 1'b0, 4'b0000, 32'h0);
        do_access(32'h100, 1'b1, 4'b0010, 32'h0000_AA00);
        do_access(32'h100, 1'b0, 4'b0000, 32'h0);
        do_access(32'h200, 1'b0, 4'b0000, 32'h0);
        do_access(32'h300, 1'b0, 4'b0000, 32'h0);
        do_access(32'h200, 1'b0, 4'b0000, 32'h0);
        do_access(32'h300, 1'b1, 4'b0000, 32'h1234_5678);

        // Reset in the middle of a refill
        fixed_delay = 40;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h400;
        t = 0;
        while (!(mem_req && !mem_we) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("abort_in_refill", {30'b0, mem_req, mem_we}, 32'd2);
        #2 rst = 1'b1;
        #1;
        check("abort_mem_req_async", 32'(mem_req), 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_no_ready", 32'(cpu_ready), 32'd0);
        rst = 1'b0;
        model_reset();
        fixed_delay = -1;

        // miss, miss, hit after the reset
        do_access(32'h200, 1'b0, 4'b0000, 32'h0);
        do_access(32'h600, 1'b0, 4'b0000, 32'h0);
        do_access(32'h200, 1'b0, 4'b0000, 32'h0);
        @(negedge clk);
        check_stats("mmh");

        // Random traffic over a small footprint to mix hits, clean and dirty misses
        for (int n = 0; n < 400; n++) begin
            bit [31:0] a;
            a = ($urandom_range(0, 47) << 2) | $urandom_range(0, 3);
            do_access(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        check_stats("final");
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sa_cache.md
# sa_cache

Two-way set-associative, write-back, write-allocate data cache that sits between the MIPS core's memory stage and the main memory model. It replaces the single-word direct-mapped cache and its separate control unit with one parametrised block. The block has a registered request/ready handshake on the core side, a req/ack handshake on the memory side, per-byte write enables and per-set LRU replacement.

## Interface
- `ADDR_W`, 32: byte-address width.
- `SETS`, 8: number of sets; power of two, ≥2. `IDX_W = $clog2(SETS)`, `TAG_W = ADDR_W-IDX_W-2`.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset: one clock; reset is asynchronous and active-high.
- `cpu_req`  in  1  access request; held with all cpu_* inputs stable until `cpu_ready`.
- `cpu_we`  in  1  1=store, 0=load.
- `cpu_be`  in  4  byte enables for stores (bit i = byte i = bits 8i+7:8i); ignored on loads.
- `cpu_addr`  in  ADDR_W  byte address; bits 1:0 ignored.
- `cpu_wdata`  in  32  store data.
- `cpu_rdata`  out  32  load data, valid while `cpu_ready`=1.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1=writeback, 0=refill read.
- `mem_addr`  out  ADDR_W  word-aligned memory address.
- `mem_wdata`  out  32  writeback data.
- `mem_rdata`  in  32  refill data, valid with `mem_ack`.
- `mem_ack`  in  1  one-cycle memory completion pulse.
- `hit_count`, `miss_count`  out  32 each  statistics (see Configuration).

## Operation
- Storage per set: 2 ways × {valid, dirty, tag[TAG_W], data[32]}, plus 1 LRU bit naming the least-recently-used way. Index = `cpu_addr[IDX_W+1:2]`; tag = `cpu_addr[ADDR_W-1:IDX_W+2]`.
- FSM states: IDLE, WRITEBACK, REFILL, RESPOND.
- IDLE with `cpu_req`=1: compare tags in both ways. On hit, go to RESPOND. On miss, select a victim: the first invalid way (way0 preferred), otherwise the LRU way. Go to WRITEBACK if the victim is valid and dirty, else to REFILL.
- WRITEBACK: `mem_req`=1, `mem_we`=1, `mem_addr`={victim tag, index, 2'b00}, `mem_wdata`=victim data. On `mem_ack`, clear the victim's dirty bit and go to REFILL.
- REFILL: `mem_req`=1, `mem_we`=0, `mem_addr`={cpu_addr[ADDR_W-1:2], 2'b00}. On `mem_ack`, write `mem_rdata` into the victim way, set valid=1, dirty=0, tag=new tag, then go to RESPOND.
- RESPOND: `cpu_ready`=1 for exactly this cycle, then return to IDLE.
  - Load: `cpu_rdata` = way data.
  - Store: merge `cpu_wdata` into the way data per `cpu_be` and set dirty=1. `be`=0000 completes but leaves data and dirty unchanged.
  - Update the set's LRU bit to the way *not* accessed.
- Invariant: a tag is never valid in both ways of one set.
- Once a request is accepted it always completes, even if `cpu_req` drops early.
- `mem_ack` outside WRITEBACK/REFILL is ignored.

## Timing
- Reset values:
  - outputs: `cpu_ready`=0, `cpu_rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, counters=0;
  - state: all valid, dirty and LRU bits=0; FSM=IDLE.
- Reset asserted mid-transaction aborts it: `mem_req` falls asynchronously, no array state survives, and no `cpu_ready` is issued.
- Hit latency: request sampled in cycle N (IDLE) → `cpu_ready` in N+1. A new request can be accepted in N+2.
- Clean miss: `mem_req` rises at N+1. The `mem_ack` cycle is followed by RESPOND, so `cpu_ready` comes one cycle after the ack.
- Dirty miss: the WRITEBACK ack is followed next cycle by REFILL `mem_req`. `mem_req` drops for zero cycles between the two phases; `mem_we`/`mem_addr` change in that cycle.
- All `mem_*` outputs are registered and stable while `mem_req`=1 until the cycle after `mem_ack`.

## Configuration
- `CACHE_STATS_EN` defined:
  - `hit_count` increments on each hit decision in IDLE;
  - `miss_count` increments on each miss decision;
  - both are 32-bit, saturate at 0xFFFFFFFF and clear on reset.
- Not defined: no counter logic is built; both ports are tied to 0.

## Test plan
- Read 0x100 after reset; memory acks 3 cycles after `mem_req` with 0xDEADBEEF → one REFILL to 0x100, `cpu_rdata`=0xDEADBEEF. A second read of 0x100 gives `cpu_ready` one cycle after the request, with no `mem_req`.
- Store 0x0000AA00 with `be`=0010 to 0x100 (hit) → no memory traffic; a subsequent load returns 0xDEADAAEF.
- Dirty-eviction sequence, with SETS=8 so all three addresses map to index 0:
  - read 0x200 (fills way1);
  - read 0x300 (way0, holding dirty 0x100, is LRU) → WRITEBACK `mem_we`=1, addr 0x100, data 0xDEADAAEF, then REFILL addr 0x300.
- Read 0x200 after the previous scenario → hit, no memory traffic. This confirms the LRU victim choice and that the clean way was kept.
- Assert `rst` while `mem_req`=1 in REFILL → `mem_req`=0 immediately and no `cpu_ready`. A read of 0x200 after release misses and issues REFILL.
- With `CACHE_STATS_EN`: miss, miss, hit sequence → `hit_count`=1, `miss_count`=2. Without the macro, both stay 0.
